// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial pattern detector.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package seq_detect_pkg;
    localparam int         DEFAULT_PAT_W     = 4;
    localparam logic [3:0] DEFAULT_RESET_PAT = 4'b1101;
    localparam logic       FOUND             = 1'b1;
    localparam logic       NOTFOUND          = 1'b0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: q updates one clock after clr/inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/seq_detect_n.sv
// Serial detector for a loadable PAT_W-bit pattern, overlapping or not.
// Latency: y is combinational in the last-bit cycle; y_q/count follow one clock later.
// Backpressure: en=0 freezes detection state; load restarts it.
module seq_detect_n
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W     = DEFAULT_PAT_W,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = DEFAULT_RESET_PAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] count
);
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q_q;
    logic [PAT_W-1:0]  shifted;

    assign shifted = {hist_q, x};

    always_comb begin
        y = NOTFOUND;
        if (en && !load && (fill_q == FILL_MAX) && (shifted == pat_q)) begin
            y = FOUND;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = shifted[PAT_W-2:0];
            // Non-overlapping mode throws the matched bits away so the next
            // match needs a full fresh pattern.
            if (y && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= RESET_PAT;
            hist_q <= '0;
            fill_q <= '0;
            y_q_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q_q  <= y;
        end
    end

    assign y_q = y_q_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .inc   (y),
        .q     (count)
    );
endmodule

// File: tb/tb_seq_detect_n.sv
// Directed bench for seq_detect_n: default instance plus a CNT_W=2 instance
// driven by the same stimulus to exercise counter saturation.
module tb_seq_detect_n;
    logic       clk = 1'b0;
    logic       reset;
    logic       x, en, load, overlap;
    logic [3:0] pattern;
    logic       y, y_q, y2, y_q2;
    logic [7:0] count;
    logic [1:0] count2;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    seq_detect_n dut (
        .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pattern(pattern),
        .overlap(overlap), .y(y), .y_q(y_q), .count(count)
    );

    seq_detect_n #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pattern(pattern),
        .overlap(overlap), .y(y2), .y_q(y_q2), .count(count2)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit, check y before the edge and y_q after it.
    task automatic bit_in(input logic b, input logic ey, input string tag);
        x    = b;
        en   = 1'b1;
        load = 1'b0;
        #1;
        chk(32'(y),  32'(ey), {tag, "_y"});
        chk(32'(y2), 32'(ey), {tag, "_y2"});
        @(posedge clk);
        #1;
        chk(32'(y_q), 32'(ey), {tag, "_yq"});
    endtask

    task automatic run(input logic [15:0] xs, input logic [15:0] ys, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(xs[i], ys[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        x     = 1'b1;
        en    = 1'b1;
        load  = 1'b0;
        #1;
        chk(32'(y),     32'd0, {tag, "_rst_y"});
        chk(32'(y_q),   32'd0, {tag, "_rst_yq"});
        chk(32'(count), 32'd0, {tag, "_rst_cnt"});
        @(posedge clk);
        #1;
        chk(32'(y), 32'd0, {tag, "_rst_y_edge"});
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        x       = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        overlap = 1'b1;
        pattern = 4'b0000;
        @(posedge clk);
        #1;

        // Overlapping detection of 1101
        do_reset("t1");
        overlap = 1'b1;
        run(16'b1101101, 16'b0001001, 7, "t1");
        chk(32'(count), 32'd2, "t1_cnt");

        // Non-overlapping: second match is lost
        do_reset("t2");
        overlap = 1'b0;
        run(16'b1101101, 16'b0001000, 7, "t2");
        chk(32'(count), 32'd1, "t2_cnt");

        // Load 0110; the load cycle would otherwise complete 1101
        overlap = 1'b1;
        run(16'b10, 16'b00, 2, "t3pre");
        x       = 1'b1;
        en      = 1'b1;
        load    = 1'b1;
        pattern = 4'b0110;
        #1;
        chk(32'(y), 32'd0, "t3_load_y");
        chk(32'(count), 32'd1, "t3_precnt");
        @(posedge clk);
        #1;
        chk(32'(count), 32'd0, "t3_load_cnt");
        chk(32'(y_q), 32'd0, "t3_load_yq");
        run(16'b0110110, 16'b0001001, 7, "t3");
        chk(32'(count), 32'd2, "t3_cnt");

        // Reset mid-stream restores 1101 and discards history
        run(16'b110, 16'b001, 3, "t4pre");
        chk(32'(count), 32'd3, "t4_precnt");
        do_reset("t4");
        run(16'b1, 16'b0, 1, "t4a");
        run(16'b1101, 16'b0001, 4, "t4b");
        chk(32'(count), 32'd1, "t4_cnt");

        // en=0 stall between bits 3 and 4
        do_reset("t5");
        run(16'b110, 16'b000, 3, "t5pre");
        for (int k = 0; k < 3; k++) begin
            x  = 1'b1;
            en = 1'b0;
            #1;
            chk(32'(y), 32'd0, $sformatf("t5_hold%0d_y", k));
            @(posedge clk);
            #1;
            chk(32'(y_q), 32'd0, $sformatf("t5_hold%0d_yq", k));
            chk(32'(count), 32'd0, $sformatf("t5_hold%0d_cnt", k));
        end
        run(16'b1, 16'b1, 1, "t5m");
        chk(32'(count), 32'd1, "t5_cnt");
        en = 1'b0;
        @(posedge clk);
        #1;
        chk(32'(y_q), 32'd0, "t5_after_yq");
        chk(32'(count), 32'd1, "t5_after_cnt");

        // Saturation of the 2-bit counter over five matches
        do_reset("t6");
        overlap = 1'b1;
        run(16'b1101, 16'b0001, 4, "t6a");
        chk(32'(count2), 32'd1, "t6_cnt2_m1");
        for (int m = 2; m <= 5; m++) begin
            run(16'b101, 16'b001, 3, $sformatf("t6m%0d", m));
            chk(32'(count2), (m < 3) ? 32'(m) : 32'd3, $sformatf("t6_cnt2_m%0d", m));
        end
        chk(32'(count), 32'd5, "t6_cnt8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detect_n.md
SEQ_DETECT_N -- requirements
Module: seq_detect_n

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter CNT_W, default 8, match-counter width.
REQ-003 Parameter RESET_PAT, default 4'b1101 (PAT_W bits), pattern in force after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 x  input  1  serial data bit, sampled on rising clk.
REQ-007 en  input  1  shift enable; 0 = hold all state.
REQ-008 load  input  1  capture new pattern and restart detection.
REQ-009 pattern  input  PAT_W  new pattern; MSB = first bit received.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 y  output  1  Mealy match flag, combinational from x and state.
REQ-012 y_q  output  1  registered copy of y, one cycle later.
REQ-013 count  output  CNT_W  saturating count of matches since reset/load.

Function
REQ-014 State: pat_q (PAT_W), hist (PAT_W-1 bits, most recent bit in LSB), fill (0..PAT_W-1), count, y_q.
REQ-015 y SHALL be 1 iff en=1, load=0, fill=PAT_W-1 and {hist, x} equals pat_q; otherwise 0.
REQ-016 Rising clk, en=1, load=0: hist shifts left with x entering the LSB; fill increments, saturating at PAT_W-1.
REQ-017 Rising clk with y=1 and overlap=0: fill SHALL become 0 (history discarded); hist still shifts.
REQ-018 Rising clk with y=1 and overlap=1: fill stays PAT_W-1; the suffix is reused.
REQ-019 Rising clk with y=1: count increments by 1; at all-ones it holds (no wrap).
REQ-020 y_q SHALL take the value of y at every rising clk, regardless of en.
REQ-021 load=1 at rising clk (priority over en): pat_q <= pattern, hist <= 0, fill <= 0, count <= 0; y = 0 that cycle.
REQ-022 en=0: pat_q, hist, fill and count hold; y = 0.
REQ-023 A change of overlap takes effect at the next match; no other state is affected.
REQ-024 Latency: y asserts combinationally in the cycle the last pattern bit is present on x; count and y_q update at the following rising clk.
REQ-025 A match requires at least PAT_W accepted bits since reset, load or the last non-overlapping match.

Reset
REQ-026 reset=0 SHALL asynchronously set pat_q = RESET_PAT, hist = 0, fill = 0, count = 0, y_q = 0; y = 0 while in reset.
REQ-027 Reset asserted mid-stream discards partial history; detection restarts from fill = 0 on the first rising clk after release.

Structure
REQ-028 Shared package seq_detect_pkg SHALL hold DEFAULT_PAT_W = 4, DEFAULT_RESET_PAT = 4'b1101, and FOUND = 1 / NOTFOUND = 0.
REQ-029 Saturating counter SHALL be a separate sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q).
REQ-030 The design SHALL contain no latches; y is driven by a fully assigned combinational block.

Verification
REQ-031 Defaults, overlap=1, x = 1,1,0,1,1,0,1 -> y=1 on bits 4 and 7; count=2.
REQ-032 Same stream, overlap=0 -> y=1 on bit 4 only; count=1.
REQ-033 load with PAT_W=4, pattern=4'b0110, then x = 0,1,1,0,1,1,0 -> y=1 on bits 4 and 7 (overlap=1); no match on the load cycle.
REQ-034 en=0 for 3 cycles inserted between bits 3 and 4 of 1101 -> y=0 while en=0; match on bit 4 once en=1; y_q follows one cycle later.
REQ-035 CNT_W=2, 5 matches -> count = 1,2,3,3,3.
REQ-036 reset pulse after bits 1,1,0 -> count=0, pat_q=1101; following x=1 gives no match; full 1101 afterwards matches.
